player_contact_damage: RTL and testbench
========================================

# player_contact_damage

Receives the boss position produced by the boss movement logic and the player position, detects body contact, and applies damage to the player. Contact damage is followed by invulnerability frames with a knockback window and a blink flag for the sprite renderer. Sits between the boss/player movement blocks and the HUD/draw blocks. All state advances only on `frame_tick`.

## Interface
- `MAX_HP`, 10, player HP at reset and on reinit (must be ≤ 15)
- `CONTACT_DMG`, 2, HP removed per contact hit
- `IFRAME_TICKS`, 60, invulnerability length in frame ticks
- `KNOCK_TICKS`, 10, leading part of the i-frames with knockback active (< `IFRAME_TICKS`)
- `FLASH_PERIOD`, 4, frame ticks per `hit_flash` toggle
- `CHAR_HALF_W`, 24, player half-width in pixels
- `CHAR_HALF_H`, 32, player half-height in pixels
- `clk` in 1 pixel clock; the only clock
- `rst_n` in 1 reset; synchronous, active-low
- `frame_tick` in 1 one-cycle pulse per frame
- `game_active` in 2 0 = reinit, 1 = run, 2/3 = freeze
- `boss_x`, `boss_y` in 12 each boss centre
- `char_x`, `char_y` in 12 each player centre
- `char_hp` out 4 current HP
- `invuln` out 1 i-frames active
- `knock_active` out 1 knockback window active
- `knock_dir` out 1 0 = push left, 1 = push right
- `hit_flash` out 1 sprite blink enable
- `player_dead` out 1 HP reached 0

## Operation
- FSM states: `VULN`, `INVULN`, `DEAD`.
- Contact is combinational: |char_x − boss_x| < `CHAR_HALF_W` + `BOSS_LNG` AND |char_y − boss_y| < `CHAR_HALF_H` + `BOSS_HGT`.
- Contact uses 13-bit signed differences. The inequalities are strict, so exactly touching edges do not hit.
- `VULN`: on a frame tick with contact, compute hp_next = sat0(char_hp − `CONTACT_DMG`).
  - If hp_next = 0, go to `DEAD`.
  - Otherwise go to `INVULN`.
  - In both cases: iframe_cnt ← `IFRAME_TICKS`, knock_dir ← (char_x < boss_x) ? 0 : 1.
  - If char_x = boss_x, knock_dir = 1.
- `INVULN`:
  - Each frame tick decrements iframe_cnt.
  - Contact is ignored.
  - `knock_active` = (iframe_cnt > `IFRAME_TICKS` − `KNOCK_TICKS`).
  - `hit_flash` toggles every `FLASH_PERIOD` ticks, starting at 1 on entry.
  - On the tick where iframe_cnt = 1, go to `VULN` and clear `hit_flash` and `knock_active`.
  - Contact is first re-evaluated on the next tick.
- `DEAD`:
  - `player_dead` = 1; `char_hp` = 0; the other flags are 0.
  - Stays here until reinit or reset.
- `game_active` = 0 (any state, `frame_tick` not required): reinit to reset values on the next clock.
- `game_active` ≥ 2: all state frozen, including counters.
- Frame ticks arriving while `game_active` ≠ 1 are ignored.

## Timing
- Reset values: `char_hp` = `MAX_HP`, state `VULN`. All flags are 0, `knock_dir` = 1, iframe_cnt = 0, flash counter = 0.
- All outputs are registered. They update on the clock edge where `frame_tick` = 1 is sampled, and are visible the cycle after.
- Hit latency: contact present at the sampled `frame_tick` → `char_hp`/`invuln` change 1 clk later.
- I-frames span exactly `IFRAME_TICKS` frame ticks, counted from the hit tick (exclusive). The earliest possible re-hit is tick `IFRAME_TICKS` + 1 after the hit.
- `knock_active` is high for exactly `KNOCK_TICKS` ticks, ending on the tick where iframe_cnt is decremented to `IFRAME_TICKS` − `KNOCK_TICKS`.
- Reset mid-`INVULN` or in `DEAD`: immediate return to reset values.
- Contact present and `game_active` dropping to 0 in the same cycle: reinit wins; no damage is applied.
- HP arithmetic saturates at 0 and never wraps.

## Structure
- `BOSS_LNG`, `BOSS_HGT`, `HOR_PIXELS`, `VER_PIXELS` come from `vga_pkg`.
- Add a `dmg_state_t` enum to `vga_pkg` so the HUD and draw blocks can decode it.
- One natural sub-module is `aabb_overlap`, a combinational box test parameterised on the two half-extents. It is reusable for player-attack-on-boss detection.
- The FSM, iframe counter and flash counter stay in this module.

## Test plan
- **Hit just inside edge.** boss at (400, 500), char_y = 500, char_x = 400 + 24 + `BOSS_LNG` − 1, one tick → `char_hp` 10→8, `invuln` = 1, `knock_dir` = 1, `knock_active` = 1, `hit_flash` = 1.
- **Exact edge.** Same as above with char_x = 400 + 24 + `BOSS_LNG` → no change, `invuln` = 0.
- **Continuous contact for 130 ticks.**
  - Hits land on ticks 1, 62 and 123 → `char_hp` 8, 6, 4.
  - `knock_active` is high on 10 ticks per hit.
  - `hit_flash` follows 1111 0000 … during i-frames.
- **Death.** Five spaced hits → `char_hp` = 0 and `player_dead` = 1 after the fifth. Further contact changes nothing. Then `game_active` = 0 → `char_hp` = 10, `player_dead` = 0.
- **Freeze.** `game_active` = 2 mid-`INVULN` for 100 ticks → iframe_cnt, `hit_flash` and `char_hp` are held. On return to 1, countdown resumes from the held value.
- **Reset mid-`INVULN`.** `rst_n` = 0 for 1 clk → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/player_contact_damage_pkg.sv
// Widths, game-mode codes and HP helper for the player contact-damage block.
package player_contact_damage_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned HP_W    = 4;
  localparam int unsigned GA_W    = 2;

  localparam logic [GA_W-1:0] GA_REINIT = 2'd0;
  localparam logic [GA_W-1:0] GA_RUN    = 2'd1;

  // HP after one hit, floored at zero
  function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                   input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? HP_W'(hp - dmg) : '0;
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// Shared display constants and the damage-state encoding decoded by the HUD and draw blocks.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;
  // Boss half-extents around its centre, in pixels
  localparam int unsigned BOSS_LNG   = 64;
  localparam int unsigned BOSS_HGT   = 48;

  typedef enum logic [1:0] {
    VULN   = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } dmg_state_t;

endpackage

// File: rtl/player_contact_damage_if.sv
// Position/mode inputs and player status outputs of the contact-damage block.
interface player_contact_damage_if;
  import player_contact_damage_pkg::*;

  logic               frame_tick;
  logic [GA_W-1:0]    game_active;
  logic [COORD_W-1:0] boss_x;
  logic [COORD_W-1:0] boss_y;
  logic [COORD_W-1:0] char_x;
  logic [COORD_W-1:0] char_y;
  logic [HP_W-1:0]    char_hp;
  logic               invuln;
  logic               knock_active;
  logic               knock_dir;
  logic               hit_flash;
  logic               player_dead;

  modport master (
    output frame_tick, game_active, boss_x, boss_y, char_x, char_y,
    input  char_hp, invuln, knock_active, knock_dir, hit_flash, player_dead
  );

  modport slave (
    input  frame_tick, game_active, boss_x, boss_y, char_x, char_y,
    output char_hp, invuln, knock_active, knock_dir, hit_flash, player_dead
  );

endinterface

// File: rtl/aabb_overlap.sv
// Combinational centre/half-extent box overlap test; touching edges do not overlap.
module aabb_overlap #(
  parameter int unsigned HALF_W  = 1,
  parameter int unsigned HALF_H  = 1,
  parameter int unsigned COORD_W = 12
) (
  input  logic [COORD_W-1:0] a_x_i,
  input  logic [COORD_W-1:0] a_y_i,
  input  logic [COORD_W-1:0] b_x_i,
  input  logic [COORD_W-1:0] b_y_i,
  output logic               overlap_o_c
);

  localparam int unsigned DW = COORD_W + 1;

  logic signed [DW-1:0] dx;
  logic signed [DW-1:0] dy;
  logic        [DW-1:0] adx;
  logic        [DW-1:0] ady;

  // One extra bit keeps the signed difference of two unsigned coordinates exact
  always_comb begin
    dx          = $signed({1'b0, a_x_i}) - $signed({1'b0, b_x_i});
    dy          = $signed({1'b0, a_y_i}) - $signed({1'b0, b_y_i});
    adx         = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
    ady         = dy[DW-1] ? $unsigned(-dy) : $unsigned(dy);
    overlap_o_c = (adx < DW'(HALF_W)) && (ady < DW'(HALF_H));
  end

endmodule

// File: rtl/player_contact_damage.sv
// Player body-contact damage: HP, i-frames with knockback window and sprite blink.
module player_contact_damage
  import vga_pkg::*;
  import player_contact_damage_pkg::*;
#(
  parameter int unsigned MAX_HP       = 10,
  parameter int unsigned CONTACT_DMG  = 2,
  parameter int unsigned IFRAME_TICKS = 60,
  parameter int unsigned KNOCK_TICKS  = 10,
  parameter int unsigned FLASH_PERIOD = 4,
  parameter int unsigned CHAR_HALF_W  = 24,
  parameter int unsigned CHAR_HALF_H  = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  player_contact_damage_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(IFRAME_TICKS + 1);
  localparam int unsigned FC_W      = $clog2(FLASH_PERIOD + 1);
  localparam int unsigned KNOCK_END = IFRAME_TICKS - KNOCK_TICKS;

  dmg_state_t        state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d, hp_hit;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              invuln_q, invuln_d;
  logic              knock_q, knock_d;
  logic              dir_q, dir_d;
  logic              flash_q, flash_d;
  logic              dead_q, dead_d;
  logic              contact;

  aabb_overlap #(
    .HALF_W (CHAR_HALF_W + BOSS_LNG),
    .HALF_H (CHAR_HALF_H + BOSS_HGT),
    .COORD_W(COORD_W)
  ) u_body (
    .a_x_i      (bus.char_x),
    .a_y_i      (bus.char_y),
    .b_x_i      (bus.boss_x),
    .b_y_i      (bus.boss_y),
    .overlap_o_c(contact)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= VULN;
      hp_q     <= HP_W'(MAX_HP);
      cnt_q    <= '0;
      fcnt_q   <= '0;
      invuln_q <= 1'b0;
      knock_q  <= 1'b0;
      dir_q    <= 1'b1;
      flash_q  <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      invuln_q <= invuln_d;
      knock_q  <= knock_d;
      dir_q    <= dir_d;
      flash_q  <= flash_d;
      dead_q   <= dead_d;
    end
  end

  // Next state; freeze (game_active >= 2) and idle cycles simply hold
  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    invuln_d = invuln_q;
    knock_d  = knock_q;
    dir_d    = dir_q;
    flash_d  = flash_q;
    dead_d   = dead_q;
    hp_hit   = hp_after_hit(hp_q, HP_W'(CONTACT_DMG));

    if (bus.game_active == GA_REINIT) begin
      state_d  = VULN;
      hp_d     = HP_W'(MAX_HP);
      cnt_d    = '0;
      fcnt_d   = '0;
      invuln_d = 1'b0;
      knock_d  = 1'b0;
      dir_d    = 1'b1;
      flash_d  = 1'b0;
      dead_d   = 1'b0;
    end else if (bus.game_active == GA_RUN && bus.frame_tick) begin
      case (state_q)
        VULN: begin
          if (contact) begin
            cnt_d = CNT_W'(IFRAME_TICKS);
            dir_d = (bus.char_x < bus.boss_x) ? 1'b0 : 1'b1;
            hp_d  = hp_hit;
            if (hp_hit == '0) begin
              state_d = DEAD;
              dead_d  = 1'b1;
            end else begin
              state_d  = INVULN;
              invuln_d = 1'b1;
              knock_d  = 1'b1;
              flash_d  = 1'b1;
              fcnt_d   = '0;
            end
          end
        end
        INVULN: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d  = VULN;
            cnt_d    = '0;
            fcnt_d   = '0;
            invuln_d = 1'b0;
            knock_d  = 1'b0;
            flash_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            knock_d = (cnt_d > CNT_W'(KNOCK_END));
            if (fcnt_q == FC_W'(FLASH_PERIOD - 1)) begin
              fcnt_d  = '0;
              flash_d = ~flash_q;
            end else begin
              fcnt_d = fcnt_q + FC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.char_hp      = hp_q;
  assign bus.invuln       = invuln_q;
  assign bus.knock_active = knock_q;
  assign bus.knock_dir    = dir_q;
  assign bus.hit_flash    = flash_q;
  assign bus.player_dead  = dead_q;

endmodule

// File: tb/tb_player_contact_damage.sv
// Bench for player_contact_damage: elapsed-tick reference model, directed scenarios, random soak.
module tb_player_contact_damage;
  import vga_pkg::*;

  localparam int MAX_HP = 10;
  localparam int DMG    = 2;
  localparam int IFR    = 60;
  localparam int KNOCK  = 10;
  localparam int FP     = 4;
  localparam int HW     = 24;
  localparam int HH     = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  player_contact_damage_if bus();

  player_contact_damage #(
    .MAX_HP(MAX_HP), .CONTACT_DMG(DMG), .IFRAME_TICKS(IFR), .KNOCK_TICKS(KNOCK),
    .FLASH_PERIOD(FP), .CHAR_HALF_W(HW), .CHAR_HALF_H(HH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: k = frame ticks elapsed since the last hit, -1 when vulnerable
  int m_hp   = MAX_HP;
  int m_k    = -1;
  bit m_dead = 1'b0;
  bit m_dir  = 1'b1;

  int ga, bx, by, cx, cy;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit touching(input int ax, input int ay, input int qx, input int qy);
    int dx, dy;
    dx = ax - qx; if (dx < 0) dx = -dx;
    dy = ay - qy; if (dy < 0) dy = -dy;
    return (dx < HW + int'(BOSS_LNG)) && (dy < HH + int'(BOSS_HGT));
  endfunction

  task automatic model_step(input bit r, input bit tick);
    if (!r || ga == 0) begin
      m_hp = MAX_HP; m_k = -1; m_dead = 1'b0; m_dir = 1'b1;
    end else if (ga == 1 && tick && !m_dead) begin
      if (m_k >= 0) begin
        m_k++;
        if (m_k >= IFR) m_k = -1;
      end else if (touching(cx, cy, bx, by)) begin
        m_hp  = (m_hp > DMG) ? m_hp - DMG : 0;
        m_dir = (cx < bx) ? 1'b0 : 1'b1;
        if (m_hp == 0) m_dead = 1'b1;
        else           m_k = 0;
      end
    end
  endtask

  // Single compare process against the model on every cycle after the first reset
  always @(negedge clk) begin
    if (chk_en) begin
      chk("char_hp",      int'(bus.char_hp),      m_hp);
      chk("invuln",       int'(bus.invuln),       int'(m_k >= 0));
      chk("knock_active", int'(bus.knock_active), int'(m_k >= 0 && m_k < KNOCK));
      chk("hit_flash",    int'(bus.hit_flash),    int'(m_k >= 0 && ((m_k / FP) % 2 == 0)));
      chk("player_dead",  int'(bus.player_dead),  int'(m_dead));
      chk("knock_dir",    int'(bus.knock_dir),    int'(m_dir));
    end
  end

  task automatic cyc(input bit r, input bit tick);
    rst_n           = r;
    bus.frame_tick  = tick;
    bus.game_active = 2'(ga);
    bus.boss_x      = 12'(bx);
    bus.boss_y      = 12'(by);
    bus.char_x      = 12'(cx);
    bus.char_y      = 12'(cy);
    @(posedge clk);
    model_step(r, tick);
    @(negedge clk);
  endtask

  task automatic frame();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
  endtask

  task automatic reinit();
    ga = 0; cyc(1'b1, 1'b0);
    ga = 1; cyc(1'b1, 1'b0);
  endtask

  int knock_cnt;
  int r, off;

  initial begin
    ga = 1; bx = 400; by = 500; cx = 100; cy = 100;
    @(negedge clk);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk_en = 1'b1;
    chk("reset hp",    int'(bus.char_hp), 10);
    chk("reset inv",   int'(bus.invuln), 0);
    chk("reset knock", int'(bus.knock_active), 0);
    chk("reset dir",   int'(bus.knock_dir), 1);
    chk("reset flash", int'(bus.hit_flash), 0);
    chk("reset dead",  int'(bus.player_dead), 0);

    // Hit just inside the horizontal edge
    cx = 400 + 24 + int'(BOSS_LNG) - 1; cy = 500;
    cyc(1'b1, 1'b1);
    chk("inside hp",    int'(bus.char_hp), 8);
    chk("inside inv",   int'(bus.invuln), 1);
    chk("inside dir",   int'(bus.knock_dir), 1);
    chk("inside knock", int'(bus.knock_active), 1);
    chk("inside flash", int'(bus.hit_flash), 1);

    // Exactly touching edge: no hit
    reinit();
    cx = 400 + 24 + int'(BOSS_LNG);
    frame();
    chk("edge hp",  int'(bus.char_hp), 10);
    chk("edge inv", int'(bus.invuln), 0);
    cx = 399;
    frame();
    chk("left dir", int'(bus.knock_dir), 0);
    chk("left hp",  int'(bus.char_hp), 8);

    // Continuous contact for 130 ticks
    reinit();
    cx = 400 + 24 + int'(BOSS_LNG) - 1;
    knock_cnt = 0;
    for (int t = 1; t <= 130; t++) begin
      cyc(1'b1, 1'b1);
      if (bus.knock_active) knock_cnt++;
      if (t == 4)   chk("flash t4", int'(bus.hit_flash), 1);
      if (t == 5)   chk("flash t5", int'(bus.hit_flash), 0);
      if (t == 9)   chk("flash t9", int'(bus.hit_flash), 1);
      if (t == 61) begin
        chk("t61 hp",  int'(bus.char_hp), 8);
        chk("t61 inv", int'(bus.invuln), 0);
      end
      if (t == 62)  chk("t62 hp", int'(bus.char_hp), 6);
      cyc(1'b1, 1'b0);
    end
    chk("t130 hp", int'(bus.char_hp), 4);
    chk("knock ticks", knock_cnt, 28);

    // Death after five hits, then reinit
    reinit();
    for (int t = 1; t <= 320; t++) frame();
    chk("dead hp",   int'(bus.char_hp), 0);
    chk("dead flag", int'(bus.player_dead), 1);
    chk("dead inv",  int'(bus.invuln), 0);
    reinit();
    chk("revive hp",   int'(bus.char_hp), 10);
    chk("revive dead", int'(bus.player_dead), 0);

    // Freeze mid-INVULN for 100 ticks
    frame();
    for (int t = 0; t < 5; t++) frame();
    ga = 2;
    for (int t = 0; t < 100; t++) frame();
    chk("frz hp",    int'(bus.char_hp), 8);
    chk("frz inv",   int'(bus.invuln), 1);
    chk("frz flash", int'(bus.hit_flash), 0);
    ga = 1;
    for (int t = 0; t < 54; t++) frame();
    chk("resume inv", int'(bus.invuln), 1);
    frame();
    chk("resume end", int'(bus.invuln), 0);

    // Reset mid-INVULN
    reinit();
    frame(); frame(); frame();
    cyc(1'b0, 1'b0);
    chk("rst hp",    int'(bus.char_hp), 10);
    chk("rst inv",   int'(bus.invuln), 0);
    chk("rst flash", int'(bus.hit_flash), 0);
    chk("rst dir",   int'(bus.knock_dir), 1);

    // Random soak
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        bx = int'($urandom_range(100, 3900));
        by = int'($urandom_range(100, 3900));
      end
      off = HW + int'(BOSS_LNG) + 4;
      cx = bx + int'($urandom_range(0, 2 * off)) - off;
      off = HH + int'(BOSS_HGT) + 4;
      cy = by + int'($urandom_range(0, 2 * off)) - off;
      if (cx < 0) cx = 0;
      if (cx > 4095) cx = 4095;
      if (cy < 0) cy = 0;
      if (cy > 4095) cy = 4095;
      r = int'($urandom_range(0, 99));
      ga = (r < 2) ? 0 : (r < 8) ? int'($urandom_range(2, 3)) : 1;
      cyc(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
